// File: rtl/hash_arbiter_pkg.sv
// Shared definitions for the SHAKE hash-core arbiter: FSM encoding,
// default requester count and SHAKE length constants.
package hash_arbiter_pkg;

    // Default number of requesters sharing one hash core
    localparam int unsigned N_REQ_DEF = 3;

    // SHAKE sponge rates in bytes (input block sizes)
    localparam logic [31:0] SHAKE128_RATE_BYTES = 32'd168;
    localparam logic [31:0] SHAKE256_RATE_BYTES = 32'd136;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_BUSY,
        ST_ABORT,
        ST_RELEASE
    } arb_state_t;

    // Index width for n requesters; never below one bit
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hash_arbiter_rr_select.sv
// Round-robin first-set-bit selector: returns the first asserted request
// at or after ptr, wrapping at N.
module rr_select
    import hash_arbiter_pkg::*;
#(
    parameter int unsigned N  = N_REQ_DEF,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan N positions starting at ptr; the first hit wins
    always_comb begin
        int unsigned cand;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/hash_arbiter.sv
// Round-robin arbiter giving N_REQ requesters exclusive access to one
// SHAKE hash core. The grantee's bus is routed to the core only in BUSY;
// a requester that drops its request mid-transaction is cleaned up by an
// arbiter-driven force_done before the core is released.
module hash_arbiter
    import hash_arbiter_pkg::*;
#(
    parameter  int unsigned N_REQ  = N_REQ_DEF,
    parameter  int unsigned ADDR_W = 10,
    localparam int unsigned IW     = idx_width(N_REQ)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    // arbitration
    input  logic [N_REQ-1:0]        i_req,
    output logic [N_REQ-1:0]        o_gnt,
    output logic [IW-1:0]           o_gnt_id,
    output logic                    o_busy,
    // requester -> core
    input  logic [N_REQ*32-1:0]     i_rq_data_in,
    input  logic [N_REQ*32-1:0]     i_rq_input_length,
    input  logic [N_REQ*32-1:0]     i_rq_output_length,
    input  logic [N_REQ-1:0]        i_rq_start,
    input  logic [N_REQ-1:0]        i_rq_data_out_ready,
    input  logic [N_REQ-1:0]        i_rq_force_done,
    // core -> requester
    output logic [N_REQ*ADDR_W-1:0] o_rq_addr,
    output logic [N_REQ-1:0]        o_rq_rd_en,
    output logic [N_REQ*32-1:0]     o_rq_data_out,
    output logic [N_REQ-1:0]        o_rq_data_out_valid,
    output logic [N_REQ-1:0]        o_rq_force_done_ack,
    // core side
    output logic [31:0]             o_hash_data_in,
    output logic [31:0]             o_hash_input_length,
    output logic [31:0]             o_hash_output_length,
    output logic                    o_hash_start,
    output logic                    o_hash_data_out_ready,
    output logic                    o_hash_force_done,
    input  logic [ADDR_W-1:0]       i_hash_addr,
    input  logic                    i_hash_rd_en,
    input  logic [31:0]             i_hash_data_out,
    input  logic                    i_hash_data_out_valid,
    input  logic                    i_hash_force_done_ack
);

    arb_state_t       state;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    sel_idx;
    logic             sel_valid;
    logic [N_REQ-1:0] sel_onehot;
    logic [N_REQ-1:0] route;

    logic [31:0] rq_data_in  [N_REQ];
    logic [31:0] rq_in_len   [N_REQ];
    logic [31:0] rq_out_len  [N_REQ];

    rr_select #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_select (
        .req   (i_req),
        .ptr   (rr_ptr),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    // One-hot form of the selected requester, loaded into o_gnt on grant
    always_comb begin
        sel_onehot          = '0;
        sel_onehot[sel_idx] = 1'b1;
    end

    // Arbitration FSM with registered grant, grantee index and busy flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            o_gnt_id <= '0;
            o_gnt    <= '0;
            o_busy   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_valid) begin
                        o_gnt_id <= sel_idx;
                        o_gnt    <= sel_onehot;
                        o_busy   <= 1'b1;
                        state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    state <= ST_BUSY;
                end
                ST_BUSY: begin
                    // completed handshake outranks a simultaneous request drop
                    if (i_rq_force_done[o_gnt_id] && i_hash_force_done_ack) begin
                        o_gnt <= '0;
                        state <= ST_RELEASE;
                    end else if (!i_req[o_gnt_id]) begin
                        o_gnt <= '0;
                        state <= ST_ABORT;
                    end
                end
                ST_ABORT: begin
                    if (i_hash_force_done_ack) begin
                        state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    rr_ptr <= (o_gnt_id == IW'(N_REQ - 1)) ? '0 : o_gnt_id + 1'b1;
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Unpack the requester buses and route core returns to the grantee only
    for (genvar g = 0; g < N_REQ; g++) begin : g_rq
        assign rq_data_in[g] = i_rq_data_in[g*32 +: 32];
        assign rq_in_len[g]  = i_rq_input_length[g*32 +: 32];
        assign rq_out_len[g] = i_rq_output_length[g*32 +: 32];

        assign route[g] = (state == ST_BUSY) && (o_gnt_id == IW'(g));

        assign o_rq_addr[g*ADDR_W +: ADDR_W] = route[g] ? i_hash_addr : '0;
        assign o_rq_data_out[g*32 +: 32]     = route[g] ? i_hash_data_out : '0;
        assign o_rq_rd_en[g]                 = route[g] & i_hash_rd_en;
        assign o_rq_data_out_valid[g]        = route[g] & i_hash_data_out_valid;
        assign o_rq_force_done_ack[g]        = route[g] & i_hash_force_done_ack;
    end

    // Core-side mux: grantee passthrough in BUSY, forced cleanup in ABORT
    always_comb begin
        o_hash_data_in        = '0;
        o_hash_input_length   = '0;
        o_hash_output_length  = '0;
        o_hash_start          = 1'b0;
        o_hash_data_out_ready = 1'b0;
        o_hash_force_done     = 1'b0;
        if (state == ST_BUSY) begin
            o_hash_data_in        = rq_data_in[o_gnt_id];
            o_hash_input_length   = rq_in_len[o_gnt_id];
            o_hash_output_length  = rq_out_len[o_gnt_id];
            o_hash_start          = i_rq_start[o_gnt_id];
            o_hash_data_out_ready = i_rq_data_out_ready[o_gnt_id];
            o_hash_force_done     = i_rq_force_done[o_gnt_id];
        end else if (state == ST_ABORT) begin
            o_hash_force_done = 1'b1;
        end
    end

endmodule

// File: tb/tb_hash_arbiter.sv
// Directed self-checking bench for hash_arbiter (N_REQ=3, ADDR_W=10).
module tb_hash_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 10;

    logic            i_clk = 1'b0;
    logic            i_rst_n;
    logic [N-1:0]    i_req;
    logic [N-1:0]    o_gnt;
    logic [1:0]      o_gnt_id;
    logic            o_busy;
    logic [N*32-1:0] i_rq_data_in, i_rq_input_length, i_rq_output_length;
    logic [N-1:0]    i_rq_start, i_rq_data_out_ready, i_rq_force_done;
    logic [N*AW-1:0] o_rq_addr;
    logic [N-1:0]    o_rq_rd_en;
    logic [N*32-1:0] o_rq_data_out;
    logic [N-1:0]    o_rq_data_out_valid, o_rq_force_done_ack;
    logic [31:0]     o_hash_data_in, o_hash_input_length, o_hash_output_length;
    logic            o_hash_start, o_hash_data_out_ready, o_hash_force_done;
    logic [AW-1:0]   i_hash_addr;
    logic            i_hash_rd_en;
    logic [31:0]     i_hash_data_out;
    logic            i_hash_data_out_valid, i_hash_force_done_ack;

    int passed = 0;
    int total  = 0;
    int gap;

    hash_arbiter #(
        .N_REQ  (N),
        .ADDR_W (AW)
    ) dut (
        .i_clk                 (i_clk),
        .i_rst_n               (i_rst_n),
        .i_req                 (i_req),
        .o_gnt                 (o_gnt),
        .o_gnt_id              (o_gnt_id),
        .o_busy                (o_busy),
        .i_rq_data_in          (i_rq_data_in),
        .i_rq_input_length     (i_rq_input_length),
        .i_rq_output_length    (i_rq_output_length),
        .i_rq_start            (i_rq_start),
        .i_rq_data_out_ready   (i_rq_data_out_ready),
        .i_rq_force_done       (i_rq_force_done),
        .o_rq_addr             (o_rq_addr),
        .o_rq_rd_en            (o_rq_rd_en),
        .o_rq_data_out         (o_rq_data_out),
        .o_rq_data_out_valid   (o_rq_data_out_valid),
        .o_rq_force_done_ack   (o_rq_force_done_ack),
        .o_hash_data_in        (o_hash_data_in),
        .o_hash_input_length   (o_hash_input_length),
        .o_hash_output_length  (o_hash_output_length),
        .o_hash_start          (o_hash_start),
        .o_hash_data_out_ready (o_hash_data_out_ready),
        .o_hash_force_done     (o_hash_force_done),
        .i_hash_addr           (i_hash_addr),
        .i_hash_rd_en          (i_hash_rd_en),
        .i_hash_data_out       (i_hash_data_out),
        .i_hash_data_out_valid (i_hash_data_out_valid),
        .i_hash_force_done_ack (i_hash_force_done_ack)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n               = 1'b0;
        i_req                 = '0;
        i_rq_data_in          = {32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
        i_rq_input_length     = {32'd302, 32'd301, 32'd300};
        i_rq_output_length    = {32'd402, 32'd401, 32'd400};
        i_rq_start            = '0;
        i_rq_data_out_ready   = 3'b010;
        i_rq_force_done       = '0;
        i_hash_addr           = '0;
        i_hash_rd_en          = 1'b0;
        i_hash_data_out       = '0;
        i_hash_data_out_valid = 1'b0;
        i_hash_force_done_ack = 1'b0;

        // reset state
        #2;
        check("rst_gnt", o_gnt, 0);
        check("rst_busy", o_busy, 0);
        check("rst_gnt_id", o_gnt_id, 0);
        check("rst_hash_fd", o_hash_force_done, 0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;

        // single request from requester 1
        @(negedge i_clk);
        i_req = 3'b010; i_rq_start = 3'b010; #1;
        check("t1_idle_no_gnt", o_gnt, 0);
        @(negedge i_clk); #1;                       // GRANT
        check("t1_gnt", o_gnt, 3'b010);
        check("t1_gnt_id", o_gnt_id, 1);
        check("t1_busy", o_busy, 1);
        check("t1_grant_no_start", o_hash_start, 0);
        @(negedge i_clk);                           // BUSY
        i_hash_data_out = 32'h1234_5678; i_hash_data_out_valid = 1'b1; #1;
        check("t1_start", o_hash_start, 1);
        check("t1_data_in", o_hash_data_in, 32'hC0DE_0001);
        check("t1_in_len", o_hash_input_length, 301);
        check("t1_out_len", o_hash_output_length, 401);
        check("t1_out_ready", o_hash_data_out_ready, 1);
        check("t1_rq_data_out", o_rq_data_out, {32'h0, 32'h1234_5678, 32'h0});
        check("t1_rq_valid", o_rq_data_out_valid, 3'b010);
        i_rq_force_done = 3'b010; i_hash_force_done_ack = 1'b1; #1;
        check("t1_fd_route", o_hash_force_done, 1);
        check("t1_fd_ack", o_rq_force_done_ack, 3'b010);
        @(negedge i_clk);                           // RELEASE
        i_rq_force_done = '0; i_hash_force_done_ack = 1'b0; i_req = '0; i_rq_start = '0; #1;
        check("t1_rel_gnt", o_gnt, 0);
        check("t1_rel_busy", o_busy, 1);
        check("t1_rel_rq_data_out", o_rq_data_out, 0);
        i_hash_data_out = '0; i_hash_data_out_valid = 1'b0;
        @(negedge i_clk); #1;                       // IDLE, rr_ptr = 2
        check("t1_idle_busy", o_busy, 0);
        check("t1_id_held", o_gnt_id, 1);

        // fairness wrap: rr_ptr = 2, requests 0 and 2
        i_req = 3'b101;
        @(negedge i_clk); #1;
        check("t2_gnt", o_gnt, 3'b100);
        check("t2_gnt_id", o_gnt_id, 2);
        @(negedge i_clk);                           // BUSY
        i_req = 3'b001; i_rq_force_done = 3'b100; i_hash_force_done_ack = 1'b1; #1;
        check("t2_data_in", o_hash_data_in, 32'hC0DE_0002);
        @(negedge i_clk);                           // RELEASE (ack beat the drop)
        i_rq_force_done = '0; i_hash_force_done_ack = 1'b0; #1;
        check("t2_rel_gnt", o_gnt, 0);
        check("t2_rel_no_abort", o_hash_force_done, 0);
        @(negedge i_clk); #1;                       // IDLE
        check("t2_gap_idle", o_gnt, 0);
        @(negedge i_clk); #1;                       // GRANT requester 0
        check("t2_gnt0", o_gnt, 3'b001);
        check("t2_gnt0_id", o_gnt_id, 0);

        // isolation with grantee 0
        @(negedge i_clk);                           // BUSY
        i_hash_data_out = 32'hDEAD_BEEF; i_hash_data_out_valid = 1'b1;
        i_hash_addr = 10'h155; i_hash_rd_en = 1'b1; #1;
        check("t3_rq_data_out", o_rq_data_out, {64'h0, 32'hDEAD_BEEF});
        check("t3_rq_valid", o_rq_data_out_valid, 3'b001);
        check("t3_rq_addr", o_rq_addr, {20'h0, 10'h155});
        check("t3_rq_rd_en", o_rq_rd_en, 3'b001);
        i_rq_force_done = 3'b001; i_hash_force_done_ack = 1'b1;
        @(negedge i_clk);                           // RELEASE, rr_ptr -> 1
        i_rq_force_done = '0; i_hash_force_done_ack = 1'b0; i_req = '0; #1;
        check("t3_rel_rq_data_out", o_rq_data_out, 0);
        check("t3_rel_rq_addr", o_rq_addr, 0);
        @(negedge i_clk);                           // IDLE
        i_hash_data_out = '0; i_hash_data_out_valid = 1'b0; i_hash_addr = '0; i_hash_rd_en = 1'b0;

        // abort: grantee 1 drops its request in BUSY
        i_req = 3'b010; i_rq_start = 3'b010;
        @(negedge i_clk); #1;                       // GRANT
        check("t4_gnt_id", o_gnt_id, 1);
        @(negedge i_clk);                           // BUSY
        i_req = '0;
        @(negedge i_clk); #1;                       // ABORT
        check("t4_abort_gnt", o_gnt, 0);
        check("t4_abort_fd", o_hash_force_done, 1);
        check("t4_abort_start", o_hash_start, 0);
        check("t4_abort_busy", o_busy, 1);
        @(negedge i_clk); #1;                       // still ABORT, no ack
        check("t4_abort_hold", o_hash_force_done, 1);
        i_hash_force_done_ack = 1'b1;
        @(negedge i_clk);                           // RELEASE, rr_ptr -> 2
        i_hash_force_done_ack = 1'b0; i_rq_start = '0; #1;
        check("t4_rel_fd", o_hash_force_done, 0);
        check("t4_rel_gnt", o_gnt, 0);
        @(negedge i_clk);                           // IDLE

        // reset in BUSY with grantee 2 (rr_ptr = 2)
        i_req = 3'b111;
        @(negedge i_clk); #1;
        check("t5_gnt", o_gnt, 3'b100);
        check("t5_gnt_id", o_gnt_id, 2);
        @(negedge i_clk);                           // BUSY
        i_hash_data_out = 32'hCAFE_F00D; i_hash_data_out_valid = 1'b1; i_rq_start = 3'b111; #1;
        check("t5_rq_data_out", o_rq_data_out, {32'hCAFE_F00D, 64'h0});
        check("t5_start", o_hash_start, 1);
        i_rst_n = 1'b0; #1;
        check("t5_rst_gnt", o_gnt, 0);
        check("t5_rst_busy", o_busy, 0);
        check("t5_rst_id", o_gnt_id, 0);
        check("t5_rst_start", o_hash_start, 0);
        check("t5_rst_rq_data_out", o_rq_data_out, 0);
        check("t5_rst_rq_valid", o_rq_data_out_valid, 0);
        check("t5_rst_fd", o_hash_force_done, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1; i_hash_data_out = '0; i_hash_data_out_valid = 1'b0; i_rq_start = '0;

        // simultaneous 3'b111 from rr_ptr = 0: grants 0,1,2
        @(negedge i_clk); #1;                       // GRANT requester 0
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t6_gnt%0d", k), o_gnt, 3'b001 << k);
            check($sformatf("t6_gnt_id%0d", k), o_gnt_id, k);
            @(negedge i_clk);                       // BUSY
            i_rq_force_done = 3'(1 << k); i_hash_force_done_ack = 1'b1;
            @(negedge i_clk);                       // RELEASE
            i_rq_force_done = '0; i_hash_force_done_ack = 1'b0; i_req[k] = 1'b0; #1;
            check($sformatf("t6_rel_gnt%0d", k), o_gnt, 0);
            if (k < 2) begin
                gap = 0;
                while (o_gnt === 3'b000 && gap < 6) begin
                    @(negedge i_clk); #1;
                    gap++;
                end
                check($sformatf("t6_gap%0d", k), gap, 2);
            end
        end
        @(negedge i_clk); #1;                       // IDLE, rr_ptr = 0
        check("t6_idle_busy", o_busy, 0);

        // single request from requester 2 with rr_ptr = 0
        i_req = 3'b100;
        @(negedge i_clk); #1;
        check("t7_gnt", o_gnt, 3'b100);
        check("t7_gnt_id", o_gnt_id, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
